// File: rtl/time_mgr_gen.sv
// time_mgr_gen: unit/epoch time manager with wait stalls, heartbeat tokens and an ahead-of-PC flag.
// Define TIME_MGR_HB_DROP_CNT_EN to add the hb_dropped overwrite counter.
module time_mgr_gen #(
    parameter int Nunit  = 16,
    parameter int Nepoch = 10,
    parameter int Ntime  = 32,
    parameter int Slack  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reset_time,
    input  logic [Nunit-1:0]  unit_len,
    input  logic [Nepoch-1:0] epoch_len,
    input  logic [Ntime-1:0]  PC_epochs_elapsed,
    input  logic              do_wait_v,
    input  logic [Nepoch-1:0] do_wait_d,
    output logic              do_wait_a,
    output logic              hb_v,
    output logic [Ntime-1:0]  hb_d,
    input  logic              hb_a,
    output logic [Ntime-1:0]  epochs_elapsed,
    output logic              epoch_tick,
    output logic              stall,
    output logic              ahead
`ifdef TIME_MGR_HB_DROP_CNT_EN
    ,
    output logic [15:0]       hb_dropped
`endif
);
    logic [Nunit-1:0]  ul_s, cyc, u_max;
    logic [Nepoch-1:0] el_s, unit, e_max, wcnt, wcnt_n;
    logic              unit_end, epoch_end;

    assign do_wait_a = do_wait_v && wcnt == '0 && !reset_time && reset_n;

    // A zero length behaves as one, so the terminal count is 0 in both cases.
    always_comb begin
        u_max     = (ul_s == '0) ? '0 : ul_s - 1'b1;
        e_max     = (el_s == '0) ? '0 : el_s - 1'b1;
        unit_end  = cyc == u_max;
        epoch_end = unit_end && unit == e_max && !reset_time;
        wcnt_n    = reset_time ? '0 :
                    do_wait_a ? do_wait_d :
                    (epoch_end && wcnt != '0) ? wcnt - 1'b1 : wcnt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ul_s           <= unit_len;
            el_s           <= epoch_len;
            cyc            <= '0;
            unit           <= '0;
            wcnt           <= '0;
            epochs_elapsed <= '0;
            epoch_tick     <= 1'b0;
            stall          <= 1'b0;
            ahead          <= 1'b0;
            hb_v           <= 1'b0;
            hb_d           <= '0;
`ifdef TIME_MGR_HB_DROP_CNT_EN
            hb_dropped     <= '0;
`endif
        end else begin
            wcnt       <= wcnt_n;
            stall      <= wcnt_n != '0;
            epoch_tick <= epoch_end;
            ahead      <= $signed(epochs_elapsed - PC_epochs_elapsed) > $signed(Ntime'(Slack));
            // Shadows track the inputs while time is held, so release starts with fresh config.
            if (reset_time || epoch_end) begin
                ul_s <= unit_len;
                el_s <= epoch_len;
            end
            if (reset_time) begin
                cyc            <= '0;
                unit           <= '0;
                epochs_elapsed <= '0;
            end else begin
                cyc <= unit_end ? '0 : cyc + 1'b1;
                if (unit_end) unit <= epoch_end ? '0 : unit + 1'b1;
                if (epoch_end) epochs_elapsed <= epochs_elapsed + 1'b1;
            end
            if (epoch_tick) begin
                hb_v <= 1'b1;
                hb_d <= epochs_elapsed;
            end else if (hb_a) begin
                hb_v <= 1'b0;
            end
`ifdef TIME_MGR_HB_DROP_CNT_EN
            if (epoch_tick && hb_v && !hb_a && hb_dropped != 16'hFFFF)
                hb_dropped <= hb_dropped + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_time_mgr_gen.sv
// tb_time_mgr_gen: directed and random stimulus against an epoch-length-in-cycles reference model.
module tb_time_mgr_gen;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0, reset_time = 1'b0;
    logic [15:0] unit_len = '0;
    logic [9:0]  epoch_len = '0;
    logic [31:0] pc = '0;
    logic        do_wait_v = 1'b0;
    logic [9:0]  do_wait_d = '0;
    logic        hb_a = 1'b0;
    logic        do_wait_a, hb_v, epoch_tick, stall, ahead;
    logic [31:0] hb_d, epochs_elapsed;
    logic [15:0] hb_dropped;
    logic        do_wait_a4, hb_v4, epoch_tick4, stall4, ahead4;
    logic [3:0]  hb_d4, ep4;
    logic [15:0] hb_dropped4;

    int tests = 0, fails = 0;

    logic [31:0] m_ep = '0, m_hbd = '0;
    int          m_pos = 0, m_len = 1, m_w = 0, m_drop = 0;
    logic        m_tick = 1'b0, m_hbv = 1'b0, m_ahead = 1'b0, exp_acc;

    always #5 clk = ~clk;

    time_mgr_gen dut (
        .clk(clk), .reset_n(reset_n), .reset_time(reset_time),
        .unit_len(unit_len), .epoch_len(epoch_len), .PC_epochs_elapsed(pc),
        .do_wait_v(do_wait_v), .do_wait_d(do_wait_d), .do_wait_a(do_wait_a),
        .hb_v(hb_v), .hb_d(hb_d), .hb_a(hb_a), .epochs_elapsed(epochs_elapsed),
        .epoch_tick(epoch_tick), .stall(stall), .ahead(ahead)
`ifdef TIME_MGR_HB_DROP_CNT_EN
        , .hb_dropped(hb_dropped)
`endif
    );

    time_mgr_gen #(.Ntime(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .reset_time(reset_time),
        .unit_len(unit_len), .epoch_len(epoch_len), .PC_epochs_elapsed(pc[3:0]),
        .do_wait_v(do_wait_v), .do_wait_d(do_wait_d), .do_wait_a(do_wait_a4),
        .hb_v(hb_v4), .hb_d(hb_d4), .hb_a(hb_a), .epochs_elapsed(ep4),
        .epoch_tick(epoch_tick4), .stall(stall4), .ahead(ahead4)
`ifdef TIME_MGR_HB_DROP_CNT_EN
        , .hb_dropped(hb_dropped4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cfg_len();
        return (unit_len == 0 ? 1 : int'(unit_len)) * (epoch_len == 0 ? 1 : int'(epoch_len));
    endfunction

    // One clock: check the acceptance handshake, advance the model, check registered outputs.
    task automatic step();
        logic bnd;
        int   diff;
        #1;
        exp_acc = do_wait_v && m_w == 0 && !reset_time && reset_n;
        chk("do_wait_a", {31'b0, do_wait_a}, {31'b0, exp_acc});
        @(posedge clk);
        if (!reset_n) begin
            m_ep = '0; m_pos = 0; m_tick = 0; m_w = 0; m_hbv = 0; m_hbd = '0;
            m_ahead = 0; m_drop = 0; m_len = cfg_len();
        end else begin
            bnd  = !reset_time && (m_pos == m_len - 1);
            diff = int'(m_ep - pc);
            if (m_tick) begin
                if (m_hbv && !hb_a && m_drop < 65535) m_drop++;
                m_hbv = 1'b1;
                m_hbd = m_ep;
            end else if (hb_a) m_hbv = 1'b0;
            m_w     = reset_time ? 0 : exp_acc ? int'(do_wait_d) : (bnd && m_w > 0) ? m_w - 1 : m_w;
            m_tick  = bnd;
            m_ahead = diff > 2;
            if (reset_time) begin
                m_ep = '0; m_pos = 0;
            end else if (bnd) begin
                m_ep++; m_pos = 0;
            end else m_pos++;
            if (reset_time || bnd) m_len = cfg_len();
        end
        #1;
        chk("epochs_elapsed", epochs_elapsed, m_ep);
        chk("epoch_tick", {31'b0, epoch_tick}, {31'b0, m_tick});
        chk("stall", {31'b0, stall}, {31'b0, m_w != 0});
        chk("hb_v", {31'b0, hb_v}, {31'b0, m_hbv});
        chk("hb_d", hb_d, m_hbd);
        chk("ahead", {31'b0, ahead}, {31'b0, m_ahead});
        chk("epochs_elapsed_n4", {28'b0, ep4}, {28'b0, m_ep[3:0]});
`ifdef TIME_MGR_HB_DROP_CNT_EN
        chk("hb_dropped", {16'b0, hb_dropped}, m_drop[31:0]);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        unit_len = 16'd3; epoch_len = 10'd2; hb_a = 1'b1;
        run(3);
        reset_n = 1'b1;
        run(20);
        unit_len = '0; epoch_len = '0;
        run(8);
        run(20);
        unit_len = 16'd2; epoch_len = 10'd1;
        run(2);
        do_wait_v = 1'b1; do_wait_d = 10'd3;
        run(16);
        do_wait_v = 1'b0;
        run(3);
        do_wait_v = 1'b1; do_wait_d = '0;
        run(5);
        do_wait_d = 10'd5;
        step();
        do_wait_v = 1'b0;
        run(3);
        reset_time = 1'b1; do_wait_v = 1'b1;
        run(3);
        reset_time = 1'b0; do_wait_v = 1'b0;
        run(2);
        hb_a = 1'b0;
        run(7);
        hb_a = 1'b1;
        step();
        hb_a = 1'b0;
        run(2);
        unit_len = '0; epoch_len = '0; pc = 32'd10;
        reset_time = 1'b1;
        step();
        reset_time = 1'b0;
        run(18);
        pc = 32'hFFFF_FFFF;
        reset_time = 1'b1;
        step();
        reset_time = 1'b0;
        run(4);
        for (int i = 0; i < 600; i++) begin
            if (i % 30 == 0) begin
                unit_len  = 16'($urandom_range(0, 4));
                epoch_len = 10'($urandom_range(0, 3));
            end
            hb_a       = 1'($urandom_range(0, 1));
            do_wait_v  = ($urandom_range(0, 3) == 0);
            do_wait_d  = 10'($urandom_range(0, 3));
            pc         = m_ep + 32'($urandom_range(0, 8)) - 32'd4;
            reset_time = ($urandom_range(0, 59) == 0);
            reset_n    = (i != 300);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
